// File: rtl/spmv_row_packer.sv
// Packs a stream of complex sparse-matrix nonzeros into 4-lane beats, one row
// at a time, with a single registered output stage and valid/ready flow control.
module spmv_row_packer #(
  parameter int unsigned MAT_RANK = 256,
  parameter int unsigned IDX_W    = $clog2(MAT_RANK)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IDX_W-1:0]     nz_col,
  input  logic [31:0]          nz_val_r,
  input  logic [31:0]          nz_val_i,
  input  logic                 nz_last,
  input  logic                 nz_empty,
  input  logic                 nz_vld,
  output logic                 nz_rdy,
  output logic [4*IDX_W-1:0]   Scol_index,
  output logic [31:0]          S_val_r0,
  output logic [31:0]          S_val_r1,
  output logic [31:0]          S_val_r2,
  output logic [31:0]          S_val_r3,
  output logic [31:0]          S_val_i0,
  output logic [31:0]          S_val_i1,
  output logic [31:0]          S_val_i2,
  output logic [31:0]          S_val_i3,
  output logic [3:0]           S_lane_mask,
  output logic                 S_row_last,
  output logic [IDX_W-1:0]     S_row_idx,
  output logic                 S_vld_o,
  input  logic                 S_rdy_o,
  output logic                 err_order
);

  localparam int unsigned LANES = 4;
  localparam int unsigned VAL_W = 32;
  localparam int unsigned CNT_W = 2;

  logic [IDX_W-1:0] r_buf_col [LANES];
  logic [VAL_W-1:0] r_buf_vr  [LANES];
  logic [VAL_W-1:0] r_buf_vi  [LANES];
  logic [CNT_W-1:0] r_cnt;

  logic [IDX_W-1:0] r_out_col [LANES];
  logic [VAL_W-1:0] r_out_vr  [LANES];
  logic [VAL_W-1:0] r_out_vi  [LANES];
  logic [LANES-1:0] r_mask;
  logic             r_row_last;
  logic             r_vld;
  logic [IDX_W-1:0] r_row;

  logic             r_err;
  logic [IDX_W-1:0] r_prev_col;
  logic             r_have_prev;

  logic             w_acc;
  logic             w_out_hs;
  logic             w_row_end;
  logic             w_close;
  logic [IDX_W-1:0] w_nxt_col [LANES];
  logic [VAL_W-1:0] w_nxt_vr  [LANES];
  logic [VAL_W-1:0] w_nxt_vi  [LANES];
  logic [LANES-1:0] w_nxt_mask;

  // Ready depends only on the output stage, never on nz_vld.
  assign nz_rdy    = !r_vld || S_rdy_o;
  assign w_acc     = nz_vld && nz_rdy;
  assign w_out_hs  = r_vld && S_rdy_o;
  assign w_row_end = nz_last || nz_empty;
  assign w_close   = w_acc && (w_row_end || (r_cnt == CNT_W'(LANES - 1)));

  // Beat image on close: buffered lanes, then the closing entry unless it marks an empty row.
  always_comb begin
    w_nxt_mask = '0;
    for (int k = 0; k < LANES; k++) begin
      w_nxt_col[k] = '0;
      w_nxt_vr[k]  = '0;
      w_nxt_vi[k]  = '0;
      if (3'(k) < 3'(r_cnt)) begin
        w_nxt_col[k]  = r_buf_col[k];
        w_nxt_vr[k]   = r_buf_vr[k];
        w_nxt_vi[k]   = r_buf_vi[k];
        w_nxt_mask[k] = 1'b1;
      end else if ((CNT_W'(k) == r_cnt) && !nz_empty) begin
        w_nxt_col[k]  = nz_col;
        w_nxt_vr[k]   = nz_val_r;
        w_nxt_vi[k]   = nz_val_i;
        w_nxt_mask[k] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < LANES; k++) begin
        r_buf_col[k] <= '0;
        r_buf_vr[k]  <= '0;
        r_buf_vi[k]  <= '0;
        r_out_col[k] <= '0;
        r_out_vr[k]  <= '0;
        r_out_vi[k]  <= '0;
      end
      r_cnt       <= '0;
      r_mask      <= '0;
      r_row_last  <= 1'b0;
      r_vld       <= 1'b0;
      r_row       <= '0;
      r_err       <= 1'b0;
      r_prev_col  <= '0;
      r_have_prev <= 1'b0;
    end else begin
      if (w_close) begin
        r_cnt <= '0;
      end else if (w_acc) begin
        r_buf_col[r_cnt] <= nz_col;
        r_buf_vr[r_cnt]  <= nz_val_r;
        r_buf_vi[r_cnt]  <= nz_val_i;
        r_cnt            <= r_cnt + CNT_W'(1);
      end

      // A close is only possible when the output stage is free or draining this cycle.
      if (w_close) begin
        for (int k = 0; k < LANES; k++) begin
          r_out_col[k] <= w_nxt_col[k];
          r_out_vr[k]  <= w_nxt_vr[k];
          r_out_vi[k]  <= w_nxt_vi[k];
        end
        r_mask     <= w_nxt_mask;
        r_row_last <= w_row_end;
        r_vld      <= 1'b1;
      end else if (w_out_hs) begin
        r_vld <= 1'b0;
      end

      if (w_out_hs && r_row_last) begin
        r_row <= (r_row == IDX_W'(MAT_RANK - 1)) ? '0 : r_row + IDX_W'(1);
      end

      // Column order watchdog; observational only.
      if (w_acc) begin
        if (nz_empty) begin
          r_have_prev <= 1'b0;
        end else begin
          if (r_have_prev && (nz_col <= r_prev_col)) r_err <= 1'b1;
          r_prev_col  <= nz_col;
          r_have_prev <= !nz_last;
        end
      end
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_col
    assign Scol_index[g*IDX_W +: IDX_W] = r_out_col[g];
  end

  assign S_val_r0    = r_out_vr[0];
  assign S_val_r1    = r_out_vr[1];
  assign S_val_r2    = r_out_vr[2];
  assign S_val_r3    = r_out_vr[3];
  assign S_val_i0    = r_out_vi[0];
  assign S_val_i1    = r_out_vi[1];
  assign S_val_i2    = r_out_vi[2];
  assign S_val_i3    = r_out_vi[3];
  assign S_lane_mask = r_mask;
  assign S_row_last  = r_row_last;
  assign S_row_idx   = r_row;
  assign S_vld_o     = r_vld;
  assign err_order   = r_err;

endmodule

// File: tb/tb_spmv_row_packer.sv
// Bench for spmv_row_packer: directed scenarios plus randomized traffic scored
// against a queue-based model of row packing (rank 256 and rank 4 instances).
module tb_spmv_row_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  nz_col;
  logic [31:0] nz_val_r, nz_val_i;
  logic        nz_last, nz_empty, nz_vld, S_rdy_o;

  logic        nz_rdy, S_row_last, S_vld_o, err_order;
  logic [31:0] Scol_index;
  logic [31:0] S_val_r0, S_val_r1, S_val_r2, S_val_r3;
  logic [31:0] S_val_i0, S_val_i1, S_val_i2, S_val_i3;
  logic [3:0]  S_lane_mask;
  logic [7:0]  S_row_idx;

  logic        nz_rdy4, row_last4, vld4, err4;
  logic [7:0]  scol4;
  logic [31:0] vr40, vr41, vr42, vr43, vi40, vi41, vi42, vi43;
  logic [3:0]  mask4;
  logic [1:0]  row4;

  spmv_row_packer u_dut (
    .clk(clk), .rst(rst), .nz_col(nz_col), .nz_val_r(nz_val_r), .nz_val_i(nz_val_i),
    .nz_last(nz_last), .nz_empty(nz_empty), .nz_vld(nz_vld), .nz_rdy(nz_rdy),
    .Scol_index(Scol_index), .S_val_r0(S_val_r0), .S_val_r1(S_val_r1),
    .S_val_r2(S_val_r2), .S_val_r3(S_val_r3), .S_val_i0(S_val_i0), .S_val_i1(S_val_i1),
    .S_val_i2(S_val_i2), .S_val_i3(S_val_i3), .S_lane_mask(S_lane_mask),
    .S_row_last(S_row_last), .S_row_idx(S_row_idx), .S_vld_o(S_vld_o),
    .S_rdy_o(S_rdy_o), .err_order(err_order)
  );

  spmv_row_packer #(.MAT_RANK(4)) u_dut4 (
    .clk(clk), .rst(rst), .nz_col(nz_col[1:0]), .nz_val_r(nz_val_r), .nz_val_i(nz_val_i),
    .nz_last(nz_last), .nz_empty(nz_empty), .nz_vld(nz_vld), .nz_rdy(nz_rdy4),
    .Scol_index(scol4), .S_val_r0(vr40), .S_val_r1(vr41), .S_val_r2(vr42), .S_val_r3(vr43),
    .S_val_i0(vi40), .S_val_i1(vi41), .S_val_i2(vi42), .S_val_i3(vi43),
    .S_lane_mask(mask4), .S_row_last(row_last4), .S_row_idx(row4), .S_vld_o(vld4),
    .S_rdy_o(S_rdy_o), .err_order(err4)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0][7:0]  col;
    logic [3:0][31:0] vr;
    logic [3:0][31:0] vi;
    logic [3:0]       mask;
    logic             last;
    logic [7:0]       row;
    logic [1:0]       row4;
  } beat_t;

  int          checks = 0;
  int          failures = 0;
  beat_t       exp_q[$];
  beat_t       seen[$];
  logic [7:0]  p_col[$];
  logic [31:0] p_vr[$];
  logic [31:0] p_vi[$];
  logic [7:0]  row_cols[$];
  int          m_row;
  logic        m_err, m_err4;
  logic        rnd_done;

  task automatic chk_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_close(input logic rl);
    beat_t b;
    b = '0;
    for (int i = 0; i < p_col.size(); i++) begin
      b.col[i]  = p_col[i];
      b.vr[i]   = p_vr[i];
      b.vi[i]   = p_vi[i];
      b.mask[i] = 1'b1;
    end
    b.last = rl;
    b.row  = 8'(m_row % 256);
    b.row4 = 2'(m_row % 4);
    if (rl) m_row++;
    exp_q.push_back(b);
    p_col.delete(); p_vr.delete(); p_vi.delete();
  endtask

  task automatic model_accept(input logic [7:0] col, input logic [31:0] vr, input logic [31:0] vi,
                              input logic last, input logic empty);
    logic [7:0] prev;
    if (!empty) begin
      if (row_cols.size() > 0) begin
        prev = row_cols[$];
        if (col <= prev) m_err = 1'b1;
        if (col[1:0] <= prev[1:0]) m_err4 = 1'b1;
      end
      row_cols.push_back(col);
      p_col.push_back(col); p_vr.push_back(vr); p_vi.push_back(vi);
    end
    if (empty || last) row_cols.delete();
    if (empty || last || p_col.size() == 4) model_close(empty || last);
  endtask

  task automatic model_reset();
    exp_q.delete(); p_col.delete(); p_vr.delete(); p_vi.delete(); row_cols.delete();
    m_row = 0; m_err = 1'b0; m_err4 = 1'b0;
  endtask

  // Scoreboard: observe at the falling edge, i.e. what the next rising edge will commit.
  always @(negedge clk) begin
    beat_t b, o;
    logic [3:0][1:0] c4;
    if (rst) begin
      model_reset();
      chk_eq("rst_vld", S_vld_o, 0);
      chk_eq("rst_mask", S_lane_mask, 0);
      chk_eq("rst_row_last", S_row_last, 0);
      chk_eq("rst_err", err_order, 0);
      chk_eq("rst_lanes", {Scol_index, S_val_r0, S_val_i3}, 0);
      chk_eq("rst_rdy", nz_rdy, 1);
    end else begin
      chk_eq("vld", S_vld_o, exp_q.size() != 0);
      chk_eq("vld4", vld4, exp_q.size() != 0);
      chk_eq("nz_rdy", nz_rdy, (exp_q.size() == 0) || S_rdy_o);
      chk_eq("err_order", err_order, m_err);
      chk_eq("err_order4", err4, m_err4);
      if (S_vld_o && S_rdy_o) begin
        if (exp_q.size() == 0) chk_eq("spurious_beat", S_vld_o, 0);
        else begin
          b = exp_q.pop_front();
          o = '0;
          o.col  = Scol_index;
          o.vr   = {S_val_r3, S_val_r2, S_val_r1, S_val_r0};
          o.vi   = {S_val_i3, S_val_i2, S_val_i1, S_val_i0};
          o.mask = S_lane_mask;
          o.last = S_row_last;
          o.row  = S_row_idx;
          o.row4 = row4;
          chk_eq("beat_col", o.col, b.col);
          chk_eq("beat_vr", o.vr, b.vr);
          chk_eq("beat_vi", o.vi, b.vi);
          chk_eq("beat_mask", o.mask, b.mask);
          chk_eq("beat_last", o.last, b.last);
          chk_eq("beat_row", o.row, b.row);
          for (int i = 0; i < 4; i++) c4[i] = b.col[i][1:0];
          chk_eq("beat4_col", scol4, c4);
          chk_eq("beat4_vals", {vr43, vr42, vr41, vr40, vi43, vi42, vi41, vi40}, {b.vr, b.vi});
          chk_eq("beat4_mask", {mask4, row_last4}, {b.mask, b.last});
          chk_eq("beat4_row", o.row4, b.row4);
          seen.push_back(o);
        end
      end
      if (nz_vld && nz_rdy) model_accept(nz_col, nz_val_r, nz_val_i, nz_last, nz_empty);
    end
  end

  task automatic send(input logic [7:0] col, input logic [31:0] vr, input logic [31:0] vi,
                      input logic last, input logic empty);
    logic ok;
    int   n;
    nz_col = col; nz_val_r = vr; nz_val_i = vi; nz_last = last; nz_empty = empty; nz_vld = 1'b1;
    n = 0;
    do begin
      @(negedge clk); ok = nz_rdy;
      @(posedge clk); #1; n++;
    end while (!ok && n < 1000);
    if (!ok) chk_eq("send_timeout", ok, 1);
    nz_vld = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk); #1; n++;
    end
    if (exp_q.size() != 0) chk_eq("drain_timeout", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    seen.delete();
  endtask

  initial begin
    int col, nent;
    logic [1:0] exp_r4 [5];
    rst = 1'b1; nz_col = '0; nz_val_r = '0; nz_val_i = '0;
    nz_last = 1'b0; nz_empty = 1'b0; nz_vld = 1'b0; S_rdy_o = 1'b1; rnd_done = 1'b0;
    model_reset();
    do_reset();

    // Six nonzeros in one row: full beat then a two-lane closing beat.
    for (int i = 0; i < 6; i++) send(8'(2*i + 1), 32'(100 + i), 32'(200 + i), i == 5, 1'b0);
    drain();
    chk_eq("t1_nbeats", seen.size(), 2);
    if (seen.size() >= 2) begin
      chk_eq("t1_b0_mask", seen[0].mask, 4'b1111);
      chk_eq("t1_b0_col", seen[0].col, {8'd7, 8'd5, 8'd3, 8'd1});
      chk_eq("t1_b0_last", seen[0].last, 0);
      chk_eq("t1_b1_mask", seen[1].mask, 4'b0011);
      chk_eq("t1_b1_col", seen[1].col, {8'd0, 8'd0, 8'd11, 8'd9});
      chk_eq("t1_b1_vr", seen[1].vr, {32'd0, 32'd0, 32'd105, 32'd104});
      chk_eq("t1_b1_last", seen[1].last, 1);
      chk_eq("t1_b1_row", seen[1].row, 0);
    end

    // Empty row marker, then the following row.
    do_reset();
    send(8'd0, 32'd0, 32'd0, 1'b1, 1'b1);
    send(8'd7, 32'd1, 32'd2, 1'b1, 1'b0);
    drain();
    chk_eq("t2_nbeats", seen.size(), 2);
    if (seen.size() >= 2) begin
      chk_eq("t2_b0_mask", seen[0].mask, 4'b0000);
      chk_eq("t2_b0_last", seen[0].last, 1);
      chk_eq("t2_b1_row", seen[1].row, 1);
    end

    // Row index wrap on the rank-4 instance.
    do_reset();
    for (int i = 0; i < 5; i++) send(8'(i), 32'(i), 32'(i), 1'b1, 1'b0);
    drain();
    exp_r4[0] = 2'd0; exp_r4[1] = 2'd1; exp_r4[2] = 2'd2; exp_r4[3] = 2'd3; exp_r4[4] = 2'd0;
    chk_eq("t3_nbeats", seen.size(), 5);
    for (int i = 0; i < 5 && i < seen.size(); i++) chk_eq("t3_row4", seen[i].row4, exp_r4[i]);

    // Output backpressure holds the beat and deasserts nz_rdy.
    S_rdy_o = 1'b0;
    send(8'd2, 32'hAAAA, 32'hBBBB, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk_eq("t4_rdy_low", nz_rdy, 0);
      chk_eq("t4_hold", {S_vld_o, S_lane_mask, Scol_index, S_val_r0}, {1'b1, 4'b0001, 32'd2, 32'hAAAA});
      @(posedge clk); #1;
    end
    S_rdy_o = 1'b1;
    @(negedge clk);
    chk_eq("t4_rdy_release", nz_rdy, 1);
    @(posedge clk); #1;
    drain();

    // Sticky order error, then reset with a half-filled buffer.
    do_reset();
    send(8'd5, 32'd1, 32'd1, 1'b0, 1'b0);
    send(8'd5, 32'd2, 32'd2, 1'b0, 1'b0);
    repeat (3) begin
      @(negedge clk); chk_eq("t5_err_sticky", err_order, 1);
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(negedge clk); chk_eq("t5_err_cleared", err_order, 0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (5) begin
      @(negedge clk); chk_eq("t5_no_stale", S_vld_o, 0);
      @(posedge clk); #1;
    end
    seen.delete();
    send(8'd9, 32'd3, 32'd4, 1'b1, 1'b0);
    drain();
    chk_eq("t5_nbeats", seen.size(), 1);
    if (seen.size() >= 1) chk_eq("t5_fresh", {seen[0].mask, seen[0].col, seen[0].row}, {4'b0001, 32'd9, 8'd0});

    // Randomized rows with random backpressure and idle gaps.
    fork
      while (!rnd_done) begin
        @(posedge clk); #1;
        S_rdy_o = ($urandom_range(0, 3) != 0);
      end
    join_none
    for (int r = 0; r < 150; r++) begin
      if ($urandom_range(0, 9) == 0) send(8'd0, $urandom, $urandom, 1'b1, 1'b1);
      else begin
        nent = $urandom_range(1, 9);
        col = $urandom_range(0, 20);
        for (int j = 0; j < nent; j++) begin
          if (j > 0 && $urandom_range(0, 19) != 0) col = col + $urandom_range(1, 20);
          send(8'(col), $urandom, $urandom, j == nent - 1, 1'b0);
          if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
        end
      end
    end
    rnd_done = 1'b1;
    @(posedge clk); #2;
    S_rdy_o = 1'b1;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
